// File: rtl/fir_wlo_pkg.sv
// Shared types and width helpers for the FIR wordlength-optimisation checker.
// Q-format: data is Q(I.F); diff/abs are Q(I+1.F); sq and sse carry 2F fractional bits.
package fir_wlo_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWarmup,
        StAccum,
        StDrain,
        StDone
    } err_mon_state_t;

    // Exact difference of two W-bit signed values needs one extra bit.
    function automatic int unsigned f_diff_wl(input int unsigned w);
        return w + 1;
    endfunction

    function automatic int unsigned f_sq_wl(input int unsigned w);
        return 2 * w + 2;
    endfunction

endpackage

// File: rtl/err_square.sv
// Two-stage error pipe: stage 1 registers |a-b|, stage 2 registers its square.
module err_square
    import fir_wlo_pkg::*;
#(
    parameter int unsigned W = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    input  logic signed [W-1:0]    a_i,
    input  logic signed [W-1:0]    b_i,
    output logic                   abs_valid_o,
    output logic [f_diff_wl(W)-1:0] abs_o,
    output logic                   sq_valid_o,
    output logic [f_sq_wl(W)-1:0]  sq_o
);

    localparam int unsigned DW = f_diff_wl(W);
    localparam int unsigned SW = f_sq_wl(W);

    logic signed [DW-1:0] diff;
    logic [DW-1:0]        abs_d, abs_q;
    logic [SW-1:0]        sq_d, sq_q;
    logic                 abs_valid_q, sq_valid_q;

    // -2^W negates to 2^W, which still fits as an unsigned DW-bit value.
    always_comb begin
        diff  = $signed({a_i[W-1], a_i}) - $signed({b_i[W-1], b_i});
        abs_d = diff[DW-1] ? (~diff + DW'(1)) : diff;
        sq_d  = SW'(abs_q) * SW'(abs_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            abs_valid_q <= 1'b0;
            abs_q       <= '0;
            sq_valid_q  <= 1'b0;
            sq_q        <= '0;
        end else begin
            abs_valid_q <= valid_i;
            sq_valid_q  <= abs_valid_q;
            if (valid_i) begin
                abs_q <= abs_d;
            end
            if (abs_valid_q) begin
                sq_q <= sq_d;
            end
        end
    end

    assign abs_valid_o = abs_valid_q;
    assign abs_o       = abs_q;
    assign sq_valid_o  = sq_valid_q;
    assign sq_o        = sq_q;

endmodule

// File: rtl/fir_err_monitor.sv
// Error monitor: discards SKIP settling samples, then accumulates saturating SSE and peak
// absolute error over N_SAMPLES valid samples of the FIR output against a golden reference.
module fir_err_monitor
    import fir_wlo_pkg::*;
#(
    parameter int unsigned DATA_INTE_WL = 4,
    parameter int unsigned DATA_FRAC_WL = 8,
    parameter int unsigned N_SAMPLES    = 1024,
    parameter int unsigned SKIP         = 15,
    parameter int unsigned ACC_WL       = 48
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   start_i,
    input  logic signed [DATA_INTE_WL+DATA_FRAC_WL-1:0] data_in_i,
    input  logic                                   in_valid_i,
    input  logic signed [DATA_INTE_WL+DATA_FRAC_WL-1:0] ref_in_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic [ACC_WL-1:0]                      sse_o,
    output logic [DATA_INTE_WL+DATA_FRAC_WL:0]     max_abs_err_o,
    output logic                                   sat_o
);

    localparam int unsigned W        = DATA_INTE_WL + DATA_FRAC_WL;
    localparam int unsigned DW       = f_diff_wl(W);
    localparam int unsigned SW       = f_sq_wl(W);
    localparam int unsigned SumW     = ACC_WL + 1;
    localparam int unsigned CntMax   = (N_SAMPLES > SKIP) ? N_SAMPLES : SKIP;
    localparam int unsigned CntW     = $clog2(CntMax + 1);
    localparam int unsigned SkipLast = (SKIP > 0) ? SKIP - 1 : 0;
    localparam int unsigned NLast    = (N_SAMPLES > 0) ? N_SAMPLES - 1 : 0;

    err_mon_state_t state_q;
    logic [CntW-1:0] cnt_q;
    logic            drain_q;
    logic            busy_q;
    logic            done_q;

    logic            start_ok;
    logic            acc_valid;

    logic            abs_valid;
    logic [DW-1:0]   abs_val;
    logic            sq_valid;
    logic [SW-1:0]   sq_val;

    logic [ACC_WL-1:0] sse_d, sse_q;
    logic [DW-1:0]     max_d, max_q;
    logic              sat_d, sat_q;
    logic [SumW-1:0]   sum;

    assign start_ok  = start_i && ((state_q == StIdle) || (state_q == StDone));
    assign acc_valid = in_valid_i && (state_q == StAccum);

    err_square #(
        .W (W)
    ) u_err_square (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (acc_valid),
        .a_i         (data_in_i),
        .b_i         (ref_in_i),
        .abs_valid_o (abs_valid),
        .abs_o       (abs_val),
        .sq_valid_o  (sq_valid),
        .sq_o        (sq_val)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        drain_q <= 1'b0;
                        state_q <= (SKIP == 0) ? StAccum : StWarmup;
                    end
                end
                StWarmup: begin
                    if (in_valid_i) begin
                        if (cnt_q == CntW'(SkipLast)) begin
                            cnt_q   <= '0;
                            state_q <= StAccum;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StAccum: begin
                    if (in_valid_i) begin
                        if (cnt_q == CntW'(NLast)) begin
                            cnt_q   <= '0;
                            state_q <= StDrain;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StDrain: begin
                    // Second drain cycle coincides with the last sse update.
                    if (drain_q) begin
                        drain_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        sse_d = sse_q;
        max_d = max_q;
        sat_d = sat_q;
        sum   = {1'b0, sse_q} + SumW'(sq_val);
        if (start_ok) begin
            sse_d = '0;
            max_d = '0;
            sat_d = 1'b0;
        end else begin
            if (abs_valid && (abs_val > max_q)) begin
                max_d = abs_val;
            end
            if (sq_valid) begin
                if (sat_q || sum[ACC_WL]) begin
                    sse_d = '1;
                    sat_d = 1'b1;
                end else begin
                    sse_d = sum[ACC_WL-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sse_q <= '0;
            max_q <= '0;
            sat_q <= 1'b0;
        end else begin
            sse_q <= sse_d;
            max_q <= max_d;
            sat_q <= sat_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign sse_o         = sse_q;
    assign max_abs_err_o = max_q;
    assign sat_o         = sat_q;

endmodule

// File: tb/tb_fir_err_monitor.sv
// Directed bench: four monitor configurations share one stimulus bus; expected results are
// queued when samples are driven and compared when the selected instance pulses done.
module tb_fir_err_monitor;

    localparam int W = 12;

    typedef struct {
        logic [47:0] sse;
        logic [12:0] mx;
        logic        sat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        start = '0;
    logic signed [W-1:0] data_in = '0;
    logic signed [W-1:0] ref_in = '0;
    logic              in_valid = 1'b0;
    logic [3:0]        busy, done, sat;
    logic [47:0]       sse_a, sse_b, sse_c;
    logic [25:0]       sse_d;
    logic [12:0]       mx_a, mx_b, mx_c, mx_d;

    logic [1:0]  sel = '0;
    logic [47:0] m_sse;
    logic [12:0] m_mx;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt[4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    fir_err_monitor #(.N_SAMPLES(16), .SKIP(0), .ACC_WL(48)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .data_in_i(data_in),
        .in_valid_i(in_valid), .ref_in_i(ref_in), .busy_o(busy[0]), .done_o(done[0]),
        .sse_o(sse_a), .max_abs_err_o(mx_a), .sat_o(sat[0]));
    fir_err_monitor #(.N_SAMPLES(8), .SKIP(4), .ACC_WL(48)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .data_in_i(data_in),
        .in_valid_i(in_valid), .ref_in_i(ref_in), .busy_o(busy[1]), .done_o(done[1]),
        .sse_o(sse_b), .max_abs_err_o(mx_b), .sat_o(sat[1]));
    fir_err_monitor #(.N_SAMPLES(8), .SKIP(0), .ACC_WL(48)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .data_in_i(data_in),
        .in_valid_i(in_valid), .ref_in_i(ref_in), .busy_o(busy[2]), .done_o(done[2]),
        .sse_o(sse_c), .max_abs_err_o(mx_c), .sat_o(sat[2]));
    fir_err_monitor #(.N_SAMPLES(5), .SKIP(0), .ACC_WL(26)) u_d (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[3]), .data_in_i(data_in),
        .in_valid_i(in_valid), .ref_in_i(ref_in), .busy_o(busy[3]), .done_o(done[3]),
        .sse_o(sse_d), .max_abs_err_o(mx_d), .sat_o(sat[3]));

    always_comb begin
        case (sel)
            2'd0:    begin m_sse = sse_a;          m_mx = mx_a; end
            2'd1:    begin m_sse = sse_b;          m_mx = mx_b; end
            2'd2:    begin m_sse = sse_c;          m_mx = mx_c; end
            default: begin m_sse = {22'b0, sse_d}; m_mx = mx_d; end
        endcase
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done[i]) done_cnt[i]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [1:0] s, input int skip, input int n, input int accwl,
                       input logic [W-1:0] rref, input int warm_diff, input int acc_diff,
                       input bit gap, input bit restart_mid, input string tag);
        exp_t   e;
        longint acc;
        int     dv, av, mx, last_edge;
        bit     st, seen;
        sel = s;
        start[s] = 1'b1;
        tick();
        start = '0;
        check({tag, "_busy"}, 48'(busy[s]), 48'd1);
        acc = 0; mx = 0; st = 1'b0; last_edge = cyc;
        for (int i = 0; i < skip + n; i++) begin
            ref_in  = rref;
            data_in = rref + W'((i < skip) ? warm_diff : acc_diff);
            dv = int'(data_in) - int'(ref_in);
            av = (dv < 0) ? -dv : dv;
            if (i >= skip) begin
                if (av > mx) mx = av;
                acc = acc + longint'(av) * longint'(av);
                if (acc > ((longint'(1) << accwl) - 1)) st = 1'b1;
            end
            in_valid = 1'b1;
            if (restart_mid && i == n / 2) start[s] = 1'b1;
            tick();
            start = '0;
            last_edge = cyc;
            if (gap) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
        e.sse = st ? ((48'd1 << accwl) - 48'd1) : 48'(acc);
        e.mx  = 13'(mx);
        e.sat = st;
        sb.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            tick();
            if (done[s]) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 48'(seen), 48'd1);
        check({tag, "_done_latency"}, 48'(cyc - last_edge), 48'd2);
        e = sb.pop_front();
        check({tag, "_sse"}, m_sse, e.sse);
        check({tag, "_max"}, 48'(m_mx), 48'(e.mx));
        check({tag, "_sat"}, 48'(sat[s]), 48'(e.sat));
        check({tag, "_busy_low"}, 48'(busy[s]), 48'd0);
        tick();
        check({tag, "_done_pulse"}, 48'(done[s]), 48'd0);
    endtask

    initial begin
        int dc;
        tick();
        tick();
        check("rst_busy", 48'(busy[0]), 48'd0);
        check("rst_done", 48'(done[0]), 48'd0);
        check("rst_sse", sse_a, 48'd0);
        check("rst_max", 48'(mx_a), 48'd0);
        check("rst_sat", 48'(sat[0]), 48'd0);
        rst_n = 1'b1;
        tick();

        run(2'd0, 0, 16, 48, 12'h100, 0, 0, 1'b0, 1'b0, "t_equal");
        run(2'd0, 0, 16, 48, 12'h100, 0, 1, 1'b0, 1'b0, "t_plus1");

        // Inputs in DONE must be dropped; results held.
        for (int i = 0; i < 4; i++) begin
            ref_in = 12'h000; data_in = 12'h400; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("hold_sse", sse_a, 48'd16);
        check("hold_max", 48'(mx_a), 48'd1);

        run(2'd1, 4, 8, 48, 12'h000, -2047, -3, 1'b0, 1'b0, "t_skip");
        run(2'd2, 0, 8, 48, 12'h020, 0, 2, 1'b1, 1'b0, "t_gaps");
        run(2'd3, 0, 5, 26, 12'h800, 0, 4095, 1'b0, 1'b0, "t_sat");

        // Reset in the middle of an accumulation.
        sel = 2'd0;
        start[0] = 1'b1;
        tick();
        start = '0;
        for (int i = 0; i < 6; i++) begin
            ref_in = 12'h010; data_in = 12'h013; in_valid = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 48'(busy[0]), 48'd0);
        check("mid_rst_done", 48'(done[0]), 48'd0);
        check("mid_rst_sse", sse_a, 48'd0);
        check("mid_rst_max", 48'(mx_a), 48'd0);
        check("mid_rst_sat", 48'(sat[0]), 48'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_after_rst", 48'(busy[0]), 48'd0);
        run(2'd0, 0, 16, 48, 12'h100, 0, 1, 1'b0, 1'b0, "t_post_rst");

        dc = done_cnt[0];
        run(2'd0, 0, 16, 48, 12'hF00, 0, -1, 1'b0, 1'b1, "t_restart_ignored");
        for (int i = 0; i < 5; i++) tick();
        check("restart_done_count", 48'(done_cnt[0] - dc), 48'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
